// File: rtl/joy_cmd_encoder.sv
// Joystick command encoder: turns held directions (with auto-repeat) and fire
// pulses into a stream of command codes through a show-ahead FIFO.
module joy_cmd_encoder #(
  parameter int unsigned REPEAT_DELAY  = 8,
  parameter int unsigned REPEAT_PERIOD = 4,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned CNT_W         = 24
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_up,
  input  logic                     i_down,
  input  logic                     i_left,
  input  logic                     i_right,
  input  logic                     i_fire,
  output logic                     o_cmd_valid,
  output logic [2:0]               o_cmd,
  input  logic                     i_cmd_ready,
  output logic                     o_overflow,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  localparam logic [2:0] CMD_NONE  = 3'd0;
  localparam logic [2:0] CMD_UP    = 3'd1;
  localparam logic [2:0] CMD_DOWN  = 3'd2;
  localparam logic [2:0] CMD_LEFT  = 3'd3;
  localparam logic [2:0] CMD_RIGHT = 3'd4;
  localparam logic [2:0] CMD_FIRE  = 3'd5;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DELAY  = 2'd1;
  localparam logic [1:0] S_REPEAT = 2'd2;

  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [2:0]       dir;
  logic [1:0]       state, next_state;
  logic [CNT_W-1:0] cnt, next_cnt;
  logic [2:0]       dir_lat, next_dir_lat;
  logic             move_req;
  logic [2:0]       move_code;

  // Priority direction select
  always_comb begin
    dir = CMD_NONE;
    if (i_up)         dir = CMD_UP;
    else if (i_down)  dir = CMD_DOWN;
    else if (i_left)  dir = CMD_LEFT;
    else if (i_right) dir = CMD_RIGHT;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      dir_lat <= CMD_NONE;
    end else begin
      state   <= next_state;
      cnt     <= next_cnt;
      dir_lat <= next_dir_lat;
    end
  end

  // Repeat FSM; advances identically whether or not the push is dropped
  always_comb begin
    next_state   = state;
    next_cnt     = cnt;
    next_dir_lat = dir_lat;
    move_req     = 1'b0;
    move_code    = dir;
    case (state)
      S_IDLE: begin
        if (dir != CMD_NONE) begin
          move_req     = 1'b1;
          next_dir_lat = dir;
          next_cnt     = '0;
          next_state   = S_DELAY;
        end
      end
      S_DELAY, S_REPEAT: begin
        if (dir == CMD_NONE) begin
          next_state = S_IDLE;
          next_cnt   = '0;
        end else if (dir != dir_lat) begin
          move_req     = 1'b1;
          next_dir_lat = dir;
          next_cnt     = '0;
        end else if (cnt == ((state == S_DELAY) ? DELAY_LAST : PERIOD_LAST)) begin
          move_req   = 1'b1;
          move_code  = dir_lat;
          next_cnt   = '0;
          next_state = S_REPEAT;
        end else begin
          next_cnt = cnt + CNT_W'(1);
        end
      end
      default: begin
        next_state = S_IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  logic [2:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt;
  logic          pop;
  logic [LW:0]   free;
  logic          we0, we1, drop;
  logic [2:0]    d0;
  logic [LW-1:0] n_push;

  assign o_cmd_valid = (o_level != '0);
  assign o_cmd       = o_cmd_valid ? mem[rd_ptr] : CMD_NONE;
  assign pop         = o_cmd_valid & i_cmd_ready;
  assign free        = (LW+1)'(DEPTH) - (LW+1)'(o_level) + (LW+1)'(pop);
  assign wr_ptr_nxt  = wr_ptr + PW'(1);
  assign n_push      = LW'(we0) + LW'(we1);

  // Push arbitration: fire takes the first free slot, move the next one
  always_comb begin
    we0  = 1'b0;
    we1  = 1'b0;
    drop = 1'b0;
    d0   = i_fire ? CMD_FIRE : move_code;
    if (i_fire && move_req) begin
      if (free >= (LW+1)'(2)) begin
        we0 = 1'b1;
        we1 = 1'b1;
      end else begin
        we0  = (free != '0);
        drop = 1'b1;
      end
    end else if (i_fire || move_req) begin
      we0  = (free != '0);
      drop = (free == '0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (we0) mem[wr_ptr] <= d0;
    if (we1) mem[wr_ptr_nxt] <= move_code;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_level    <= '0;
      o_overflow <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr + PW'(n_push);
      rd_ptr  <= rd_ptr + PW'(pop);
      o_level <= o_level + n_push - LW'(pop);
      if (drop) o_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_joy_cmd_encoder.sv
// Directed bench for joy_cmd_encoder with DELAY=8, PERIOD=4, DEPTH=4.
module tb_joy_cmd_encoder;

  logic       clk = 1'b0;
  logic       rst, up, down, left, right, fire, ready;
  logic       cmd_valid, overflow;
  logic [2:0] cmd;
  logic [2:0] level;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  joy_cmd_encoder #(
    .REPEAT_DELAY(8), .REPEAT_PERIOD(4), .DEPTH(4), .CNT_W(24)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_up(up), .i_down(down), .i_left(left),
    .i_right(right), .i_fire(fire), .o_cmd_valid(cmd_valid), .o_cmd(cmd),
    .i_cmd_ready(ready), .o_overflow(overflow), .o_level(level)
  );

  // One rising edge, then settle to the falling edge for sampling/driving
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; up = 0; down = 0; left = 0; right = 0; fire = 0; ready = 0;
    tick();
    tick();
    vecs++;
    if (cmd_valid !== 1'b0 || cmd !== 3'd0 || level !== 3'd0 || overflow !== 1'b0) begin
      errs++;
      $display("FAIL reset: valid=%b cmd=%0d level=%0d ovf=%b, want 0 0 0 0",
               cmd_valid, cmd, level, overflow);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_repeat();
    logic       ev;
    ready = 1'b1;
    up = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      tick();
      ev = (k == 0 || k == 8 || k == 12 || k == 16 || k == 20);
      vecs++;
      if (cmd_valid !== ev || cmd !== (ev ? 3'd1 : 3'd0)) begin
        errs++;
        $display("FAIL repeat edge %0d: valid=%b cmd=%0d, want %b %0d",
                 k, cmd_valid, cmd, ev, ev ? 1 : 0);
      end
    end
    up = 1'b0;
    for (int k = 21; k <= 30; k++) begin
      tick();
      vecs++;
      if (cmd_valid !== 1'b0) begin
        errs++;
        $display("FAIL release edge %0d: valid=%b want 0", k, cmd_valid);
      end
    end
  endtask

  task automatic test_dir_change();
    logic [2:0] ec;
    ready = 1'b1;
    up = 1'b1; left = 1'b1;
    for (int k = 0; k <= 15; k++) begin
      if (k == 5) up = 1'b0;
      tick();
      ec = (k == 0) ? 3'd1 : (k == 5 || k == 13) ? 3'd3 : 3'd0;
      vecs++;
      if (cmd_valid !== (ec != 3'd0) || cmd !== ec) begin
        errs++;
        $display("FAIL dir_change edge %0d: valid=%b cmd=%0d, want cmd %0d",
                 k, cmd_valid, cmd, ec);
      end
    end
    left = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_fire_move();
    ready = 1'b0;
    fire = 1'b1; right = 1'b1;
    tick();
    fire = 1'b0; right = 1'b0;
    vecs++;
    if (level !== 3'd2 || cmd_valid !== 1'b1 || cmd !== 3'd5) begin
      errs++;
      $display("FAIL fire_move push: level=%0d valid=%b cmd=%0d, want 2 1 5", level, cmd_valid, cmd);
    end
    tick();
    vecs++;
    if (level !== 3'd2 || cmd !== 3'd5) begin
      errs++;
      $display("FAIL fire_move hold: level=%0d cmd=%0d, want 2 5", level, cmd);
    end
    ready = 1'b1;
    tick();
    vecs++;
    if (level !== 3'd1 || cmd !== 3'd4) begin
      errs++;
      $display("FAIL fire_move second: level=%0d cmd=%0d, want 1 4", level, cmd);
    end
    tick();
    tick();
    vecs++;
    if (level !== 3'd0 || cmd_valid !== 1'b0 || cmd !== 3'd0) begin
      errs++;
      $display("FAIL fire_move empty: level=%0d valid=%b cmd=%0d, want 0 0 0", level, cmd_valid, cmd);
    end
  endtask

  task automatic test_overflow();
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      fire = 1'b1;
      tick();
      fire = 1'b0;
      tick();
      vecs++;
      if (level !== ((i < 4) ? 3'(i + 1) : 3'd4) || overflow !== (i == 4)) begin
        errs++;
        $display("FAIL overflow fill %0d: level=%0d ovf=%b, want %0d %b",
                 i, level, overflow, (i < 4) ? i + 1 : 4, i == 4);
      end
    end
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if (cmd_valid !== 1'b1 || cmd !== 3'd5) begin
        errs++;
        $display("FAIL overflow drain %0d: valid=%b cmd=%0d, want 1 5", i, cmd_valid, cmd);
      end
      tick();
    end
    vecs++;
    if (cmd_valid !== 1'b0 || level !== 3'd0 || overflow !== 1'b1) begin
      errs++;
      $display("FAIL overflow end: valid=%b level=%0d ovf=%b, want 0 0 1", cmd_valid, level, overflow);
    end
    ready = 1'b0;
    do_reset();
    vecs++;
    if (overflow !== 1'b0) begin
      errs++;
      $display("FAIL overflow clear: ovf=%b want 0", overflow);
    end
  endtask

  task automatic test_full_pop_fire();
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fire = 1'b1;
      tick();
      fire = 1'b0;
    end
    ready = 1'b1; fire = 1'b1;
    tick();
    ready = 1'b0; fire = 1'b0;
    vecs++;
    if (level !== 3'd4 || overflow !== 1'b0) begin
      errs++;
      $display("FAIL full_pop_fire: level=%0d ovf=%b, want 4 0", level, overflow);
    end
    ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    ready = 1'b0;
    vecs++;
    if (level !== 3'd0 || overflow !== 1'b0) begin
      errs++;
      $display("FAIL full_pop_fire drain: level=%0d ovf=%b, want 0 0", level, overflow);
    end
  endtask

  task automatic test_partial_drop();
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fire = 1'b1;
      tick();
      fire = 1'b0;
    end
    fire = 1'b1; up = 1'b1;
    tick();
    fire = 1'b0; up = 1'b0;
    vecs++;
    if (level !== 3'd4 || overflow !== 1'b1) begin
      errs++;
      $display("FAIL partial_drop: level=%0d ovf=%b, want 4 1", level, overflow);
    end
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if (cmd !== 3'd5) begin
        errs++;
        $display("FAIL partial_drop entry %0d: cmd=%0d want 5", i, cmd);
      end
      tick();
    end
    vecs++;
    if (cmd_valid !== 1'b0) begin
      errs++;
      $display("FAIL partial_drop empty: valid=%b want 0", cmd_valid);
    end
    ready = 1'b0;
    do_reset();
  endtask

  task automatic test_reset_mid_repeat();
    logic ev;
    ready = 1'b1;
    down = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      tick();
      ev = (k == 0 || k == 8);
      vecs++;
      if (cmd_valid !== ev || cmd !== (ev ? 3'd2 : 3'd0)) begin
        errs++;
        $display("FAIL pre_reset edge %0d: valid=%b cmd=%0d, want %b", k, cmd_valid, cmd, ev);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vecs++;
    if (cmd_valid !== 1'b0 || cmd !== 3'd0 || level !== 3'd0 || overflow !== 1'b0) begin
      errs++;
      $display("FAIL mid_reset: valid=%b cmd=%0d level=%0d ovf=%b, want 0 0 0 0",
               cmd_valid, cmd, level, overflow);
    end
    for (int k = 12; k <= 21; k++) begin
      tick();
      ev = (k == 12 || k == 20);
      vecs++;
      if (cmd_valid !== ev || cmd !== (ev ? 3'd2 : 3'd0)) begin
        errs++;
        $display("FAIL post_reset edge %0d: valid=%b cmd=%0d, want %b", k, cmd_valid, cmd, ev);
      end
    end
    down = 1'b0;
    tick();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_repeat();
    test_dir_change();
    test_fire_move();
    test_overflow();
    test_full_pop_fire();
    test_partial_drop();
    test_reset_mid_repeat();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/joy_cmd_encoder.md
Name: joy_cmd_encoder

Overview:
Consumer side of the joystick front end. Takes the debounced direction levels and the fire pulse and turns them into a stream of discrete game commands on a valid/ready interface.
- Held directions auto-repeat after a delay.
- Commands are buffered in a small FIFO so the game FSM can apply backpressure.
- Sits between the joystick debouncers and the game logic.

Parameters:
- REPEAT_DELAY, 8, cycles a direction must be held after its first command before the first auto-repeat (>=2).
- REPEAT_PERIOD, 4, cycles between auto-repeats while held (>=2).
- DEPTH, 4, command FIFO entries (power of two, >=2).
- CNT_W, 24, width of the repeat counter (must hold max(REPEAT_DELAY, REPEAT_PERIOD)).

Ports:
- i_clk  in  1  system clock, all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_up  in  1  debounced level, 1 = held.
- i_down  in  1  debounced level, 1 = held.
- i_left  in  1  debounced level, 1 = held.
- i_right  in  1  debounced level, 1 = held.
- i_fire  in  1  single-cycle pulse per fire press.
- o_cmd_valid  out  1  FIFO head valid.
- o_cmd  out  3  FIFO head code: 1=UP 2=DOWN 3=LEFT 4=RIGHT 5=FIRE; 0 when not valid.
- i_cmd_ready  in  1  consumer accepts head when high with o_cmd_valid.
- o_overflow  out  1  sticky; set when any command is dropped, cleared only by reset.
- o_level  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
Reset (i_rst high at a rising edge):
- FSM to IDLE, counter=0, FIFO emptied.
- o_cmd_valid=0, o_cmd=0, o_overflow=0, o_level=0.
- Any in-flight repeat is abandoned. No command is generated in the reset cycle.
- After reset deasserts, a direction already held is treated as a new press in the first non-reset cycle.

Direction select (combinational):
- dir = priority UP > DOWN > LEFT > RIGHT over the held inputs; NONE if none held.
- dir_lat register holds the direction currently being tracked.

Repeat FSM, states IDLE, DELAY, REPEAT:
- IDLE:
  - dir != NONE: request a move push of dir, latch dir_lat=dir, cnt=0, go to DELAY.
- DELAY:
  - dir == NONE: go to IDLE, no push.
  - dir != dir_lat: treat as a new press (push dir, relatch, cnt=0, stay in DELAY).
  - Otherwise, if cnt == REPEAT_DELAY-1: push dir_lat, cnt=0, go to REPEAT.
  - Otherwise cnt++.
- REPEAT:
  - Same as DELAY, but the terminal count is REPEAT_PERIOD-1 and the state stays REPEAT.
- Release and re-press within one cycle is seen as a new press and pushes immediately.

Fire:
- Every i_fire pulse requests a FIRE push.
- Fire is independent of the FSM and does not reset cnt.

Push arbitration (up to 2 requests per cycle):
- free = DEPTH - o_level + (o_cmd_valid & i_cmd_ready). A pop in the same cycle frees a slot.
- Fire is written first, then the move command.
- Both requested and free >= 2: both written, FIRE ahead of the move.
- Both requested and free == 1: FIRE written, move dropped, o_overflow set.
- Single request and free == 0: that command is dropped, o_overflow set.
- The FSM advances (cnt, state, dir_lat) exactly as if the push succeeded. Drops never stall repeat timing.

FIFO:
- Show-ahead (first-word-fall-through) FIFO.
- A command pushed at edge N is visible on o_cmd/o_cmd_valid after edge N, i.e. 1-cycle latency from the input sample.
- Pop occurs on an edge where o_cmd_valid & i_cmd_ready.
- Read and write pointers are wrapped modulo DEPTH; o_level changes by pushes minus pop each edge.
- o_cmd is 0 whenever empty.
- i_cmd_ready while empty has no effect.
- o_cmd_valid and o_cmd are stable while not accepted.

Test Plan:
- i_up rises and is sampled at edge 0, held 20 cycles, ready=1 (DELAY=8, PERIOD=4) -> UP visible after edges 0, 8, 12, 16, 20; nothing after release.
- i_up and i_left held together from edge 0, then i_up drops at edge 5 -> UP after edge 0, LEFT after edge 5, next LEFT after edge 13.
- i_fire pulse and i_right press on the same edge, FIFO empty -> o_level=2, head FIRE(5) then RIGHT(4) on consecutive accepted cycles.
- ready=0, issue 5 fire pulses on separate cycles (DEPTH=4) -> o_level saturates at 4 and o_overflow=1. Raise ready -> exactly 4 FIREs drained, o_overflow stays 1.
- FIFO full, same edge has pop (ready=1) plus one fire pulse -> fire accepted, o_level stays 4, o_overflow stays 0.
- Hold i_down into REPEAT, assert i_rst for 1 cycle at edge 11 with i_down still held -> outputs and o_level cleared. DOWN pushed at the first post-reset edge, first repeat REPEAT_DELAY edges later.
